// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the shared register-file write port.
// Drops writes to the zero register and counts committed port writes.
module regfile_wb_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int ZR_IDX = 31,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic              Hold,
    input  logic              ValidA,
    input  logic [ADDR_W-1:0] RWA,
    input  logic [DATA_W-1:0] BusWA,
    output logic              ReadyA,
    input  logic              ValidB,
    input  logic [ADDR_W-1:0] RWB,
    input  logic [DATA_W-1:0] BusWB,
    output logic              ReadyB,
    output logic              RegWr,
    output logic [ADDR_W-1:0] RW,
    output logic [DATA_W-1:0] BusW,
    output logic              Prio,
    output logic [CNT_W-1:0]  WrCount
);

    localparam logic [ADDR_W-1:0] ZR      = ADDR_W'(ZR_IDX);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic              r_regwr;
    logic [ADDR_W-1:0] r_rw;
    logic [DATA_W-1:0] r_busw;
    logic              r_prio;
    logic [CNT_W-1:0]  r_cnt;

    logic w_zero_a;
    logic w_zero_b;
    logic w_real_a;
    logic w_real_b;
    logic w_grant_a;
    logic w_grant_b;

    assign w_zero_a = ValidA && (RWA == ZR);
    assign w_zero_b = ValidB && (RWB == ZR);
    assign w_real_a = ValidA && (RWA != ZR);
    assign w_real_b = ValidB && (RWB != ZR);

    // Prio=0 favours A on a tie, Prio=1 favours B.
    assign w_grant_a = Reset_L && !Hold && w_real_a
                       && (!w_real_b || !r_prio);
    assign w_grant_b = Reset_L && !Hold && w_real_b
                       && (!w_real_a || r_prio);

    assign ReadyA = w_grant_a || (Reset_L && !Hold && w_zero_a);
    assign ReadyB = w_grant_b || (Reset_L && !Hold && w_zero_b);

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_regwr <= 1'b0;
            r_rw    <= ZR;
            r_busw  <= '0;
            r_prio  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_regwr <= w_grant_a || w_grant_b;
            if (w_grant_a) begin
                r_rw   <= RWA;
                r_busw <= BusWA;
                r_prio <= 1'b1;
            end else if (w_grant_b) begin
                r_rw   <= RWB;
                r_busw <= BusWB;
                r_prio <= 1'b0;
            end
            if ((w_grant_a || w_grant_b) && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign RegWr   = r_regwr;
    assign RW      = r_rw;
    assign BusW    = r_busw;
    assign Prio    = r_prio;
    assign WrCount = r_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter.
// A cycle-level reference model predicts Ready and port outputs.
module tb_regfile_wb_arbiter;

    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic        CLK;
    logic        Reset_L;
    logic        Hold;
    logic        ValidA;
    logic [4:0]  RWA;
    logic [63:0] BusWA;
    logic        ReadyA;
    logic        ValidB;
    logic [4:0]  RWB;
    logic [63:0] BusWB;
    logic        ReadyB;
    logic        RegWr;
    logic [4:0]  RW;
    logic [63:0] BusW;
    logic        Prio;
    logic [CW-1:0] WrCount;

    regfile_wb_arbiter #(.CNT_W(CW)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .Hold(Hold),
        .ValidA(ValidA), .RWA(RWA), .BusWA(BusWA), .ReadyA(ReadyA),
        .ValidB(ValidB), .RWB(RWB), .BusWB(BusWB), .ReadyB(ReadyB),
        .RegWr(RegWr), .RW(RW), .BusW(BusW), .Prio(Prio),
        .WrCount(WrCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state
    bit          m_regwr;
    bit [4:0]    m_rw;
    bit [63:0]   m_busw;
    bit          m_pref_b;
    int          m_cnt;
    bit          m_acc_a;
    bit          m_acc_b;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_regwr  = 0;
        m_rw     = 5'd31;
        m_busw   = 0;
        m_pref_b = 0;
        m_cnt    = 0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_regwr"}, RegWr, m_regwr);
        chk({tag, "_rw"}, RW, m_rw);
        chk({tag, "_busw"}, BusW, m_busw);
        chk({tag, "_prio"}, Prio, m_pref_b);
        chk({tag, "_cnt"}, WrCount, m_cnt);
    endtask

    // Inputs are set before the call; checks Ready, clocks, checks outputs.
    task automatic cycle(input string tag);
        bit real_a, real_b, win_a, win_b;
        #1;
        real_a = ValidA && RWA != 5'd31;
        real_b = ValidB && RWB != 5'd31;
        win_a = 0;
        win_b = 0;
        if (!Hold) begin
            if (real_a && real_b) begin
                win_a = !m_pref_b;
                win_b = m_pref_b;
            end else begin
                win_a = real_a;
                win_b = real_b;
            end
        end
        m_acc_a = !Hold && ValidA && (win_a || RWA == 5'd31);
        m_acc_b = !Hold && ValidB && (win_b || RWB == 5'd31);
        chk({tag, "_readyA"}, ReadyA, m_acc_a);
        chk({tag, "_readyB"}, ReadyB, m_acc_b);
        @(posedge CLK);
        #1;
        m_regwr = win_a || win_b;
        if (win_a) begin
            m_rw = RWA; m_busw = BusWA; m_pref_b = 1;
        end else if (win_b) begin
            m_rw = RWB; m_busw = BusWB; m_pref_b = 0;
        end
        if (m_regwr && m_cnt < CMAX) m_cnt++;
        chk_outputs(tag);
    endtask

    task automatic idle_inputs();
        Hold = 0; ValidA = 0; ValidB = 0;
        RWA = 0; RWB = 0; BusWA = 0; BusWB = 0;
    endtask

    task automatic do_reset();
        Reset_L = 0;
        model_reset();
        #1;
        @(posedge CLK);
        #3;
        Reset_L = 1;
        #1;
    endtask

    initial begin
        idle_inputs();
        Reset_L = 1;
        #2;
        ValidA = 1; RWA = 5'd3;
        do_reset();
        // Reset state, with A valid while reset asserted
        Reset_L = 0;
        #1;
        chk("rst_readyA", ReadyA, 1'b0);
        chk("rst_regwr", RegWr, 1'b0);
        chk("rst_rw", RW, 5'd31);
        chk("rst_busw", BusW, 64'h0);
        chk("rst_prio", Prio, 1'b0);
        chk("rst_cnt", WrCount, 4'd0);
        #1 Reset_L = 1;
        idle_inputs();
        @(posedge CLK); #1;

        // 1: single A write
        ValidA = 1; RWA = 5'd3; BusWA = 64'hAA;
        cycle("t1");
        chk("t1_rw_exp", RW, 5'd3);
        chk("t1_bus_exp", BusW, 64'hAA);
        chk("t1_cnt_exp", WrCount, 4'd1);
        ValidA = 0;

        // 2: back-to-back alternation from reset
        do_reset();
        ValidA = 1; RWA = 5'd1; BusWA = 64'h101;
        ValidB = 1; RWB = 5'd2; BusWB = 64'h202;
        for (int i = 0; i < 4; i++) begin
            cycle("t2");
            chk("t2_rw_seq", RW, (i % 2 == 0) ? 5'd1 : 5'd2);
            chk("t2_prio_seq", Prio, (i % 2 == 0) ? 1'b1 : 1'b0);
        end
        chk("t2_cnt_exp", WrCount, 4'd4);

        // 3: same destination, Prio=0: A first then B
        ValidA = 1; RWA = 5'd5; BusWA = 64'h11;
        ValidB = 1; RWB = 5'd5; BusWB = 64'h22;
        cycle("t3a");
        chk("t3_first", BusW, 64'h11);
        ValidA = 0;
        cycle("t3b");
        chk("t3_final", BusW, 64'h22);
        chk("t3_rw", RW, 5'd5);
        ValidB = 0;
        cycle("t3idle");

        // 4: A to zero register, B real
        ValidA = 1; RWA = 5'd31; BusWA = 64'h99;
        ValidB = 1; RWB = 5'd7; BusWB = 64'h33;
        cycle("t4");
        chk("t4_rw", RW, 5'd7);
        chk("t4_bus", BusW, 64'h33);
        idle_inputs();
        cycle("t4idle");
        chk("t4_single", RegWr, 1'b0);

        // 5: Hold with both valid
        ValidA = 1; RWA = 5'd8; BusWA = 64'h808;
        ValidB = 1; RWB = 5'd9; BusWB = 64'h909;
        Hold = 1;
        for (int i = 0; i < 3; i++) cycle("t5hold");
        Hold = 0;
        cycle("t5rel");
        chk("t5_prio_side", RW, Prio ? 5'd8 : 5'd9);
        idle_inputs();

        // 6: asynchronous reset right after a grant
        ValidA = 1; RWA = 5'd4; BusWA = 64'h44;
        cycle("t6");
        ValidA = 0;
        #2 Reset_L = 0;
        model_reset();
        #1;
        chk_outputs("t6_async");
        @(posedge CLK); #2;
        Reset_L = 1;
        cycle("t6post");

        // Saturation of the committed-write counter
        ValidA = 1; RWA = 5'd6;
        for (int i = 0; i < CMAX + 4; i++) begin
            BusWA = 64'(i);
            cycle("sat");
        end
        chk("sat_cnt", WrCount, 4'hF);
        idle_inputs();

        // Randomized traffic obeying the hold-until-accepted rule
        do_reset();
        m_acc_a = 1; m_acc_b = 1;
        for (int i = 0; i < 400; i++) begin
            if (!ValidA || m_acc_a) begin
                ValidA = ($urandom % 4) != 0;
                RWA = ($urandom % 6 == 0) ? 5'd31 : 5'($urandom);
                BusWA = {$urandom, $urandom};
            end
            if (!ValidB || m_acc_b) begin
                ValidB = ($urandom % 4) != 0;
                RWB = ($urandom % 6 == 0) ? 5'd31 : 5'($urandom);
                BusWB = {$urandom, $urandom};
            end
            Hold = ($urandom % 8) == 0;
            cycle("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
